err_diffuse_ctrl: RTL and testbench
===================================

Name: err_diffuse_ctrl

Overview:
Sequencer for the Floyd-Steinberg error-diffusion datapath in the e-paper pixel pipeline.
- Per pixel, it adds the incoming 8-bit grey value to the error carried from the left and the error stored from the line above.
- It saturates the sum 11->9 bits signed, quantizes to OUT_BITS, and splits the residual error 7/3/5/1 (sixteenths) to the four neighbours.
- It owns the external dual-port error line buffer and the pixel in/out handshakes.

Parameters:
H_ACTIVE, 1600, active pixels per line
ADDR_W, 11, error-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE
OUT_BITS, 4, quantized output depth, 1..8

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  single-cycle pulse; restarts at pixel 0 of a first line
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts a pixel this cycle
in_pixel  in  8  unsigned grey value
out_valid  out  1  quantized pixel valid
out_ready  in  1  downstream accepts
out_pixel  out  OUT_BITS  quantized value
eb_rd_en  out  1  error-buffer read strobe
eb_rd_addr  out  ADDR_W  read address
eb_rd_data  in  9  signed error; valid the cycle after eb_rd_en
eb_wr_en  out  1  error-buffer write strobe
eb_wr_addr  out  ADDR_W  write address
eb_wr_data  out  9  signed error to store

Behaviour:
- Reset and clock: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, x=0, first_line=1, err_r=0, acc_m1=acc_0=acc_p1=0, all outputs 0. Exception: in_ready=1 in IDLE.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch in_pixel, pulse eb_rd_en with eb_rd_addr=x, go to READ.
  - READ: wait one cycle for RAM latency, go to SUM.
  - SUM:
    - Form ea = first_line ? 0 : eb_rd_data.
    - s = zext11(pixel) + sext11(ea) + sext11(err_r).
    - Saturate s to 9 bits signed: if s < -256 then -256; if s > 255 then 255; else s[8:0].
    - q = (c < 0) ? 0 : c[7:8-OUT_BITS].
    - recon = q << (8-OUT_BITS).
    - e = c - recon, 9-bit signed.
    - Register out_pixel=q and e, go to EMIT.
  - EMIT:
    - out_valid=1, held with out_pixel stable until out_ready.
    - In the accept cycle, update the carries (terms are (e*k)>>>4, arithmetic):
      - err_r <= (x==H_ACTIVE-1) ? 0 : 7e/16.
      - acc_m1 += 3e/16, dropped if x==0.
      - acc_0 += 5e/16.
      - acc_p1 = e/16.
    - If x>=1, write eb_wr_addr=x-1, eb_wr_data=updated acc_m1.
    - Then shift acc_m1<=acc_0, acc_0<=acc_p1, acc_p1<=0.
    - If x==H_ACTIVE-1, go to FLUSH; else x++ and go to IDLE.
  - FLUSH:
    - Write acc_m1 to addr H_ACTIVE-1 (the x+1 contribution beyond the edge is discarded).
    - Clear accumulators and err_r, x=0, first_line=0, go to IDLE.
- Throughput: 4 cycles per pixel when out_ready is held high; 1 extra cycle per line.
- Port-to-port latency: in accept to out_valid = 3 cycles.
- Read/write ordering: a write to address x-1 never collides with the read of address x; reads and writes go to distinct addresses in distinct cycles.
- frame_start in any state: abort the current pixel (out_valid drops, no write), clear x, err_r and accumulators, set first_line=1, go to IDLE. Same-cycle in_valid is ignored.
- Width rules:
  - Sum range is [-256-256, 255+255+255], which fits 11-bit signed.
  - e lies in [-256, 2^(8-OUT_BITS)-1], which fits 9 bits.
  - Accumulators are 9-bit signed; no wrap is possible.

Optional Feature:
ERR_SAT_STATS_EN
- Defined:
  - Adds output sat_count (16 bits), counting pixels where the 11->9 saturation clipped in SUM.
  - The counter saturates at 0xFFFF and clears on rst or frame_start.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package err_diffuse_pkg holds:
  - state enum (IDLE, READ, SUM, EMIT, FLUSH);
  - ERR_W=9, SUM_W=11;
  - diffusion weights 7, 3, 5, 1 and shift 4.
- One sub-module, err_diffuse_calc: the SUM-stage combinational path (sum, saturate, quantize, residual). It is instantiated once and sequenced by the FSM.

Test Plan:
1. first_line, OUT_BITS=4, pixels 128,128 -> pixel0: c=128, q=8, e=0, out 8; pixel1: err_r=0, out 8; eb writes 0 at addr 0.
2. first_line, pixel 0x0F then 0x00 -> e=15, err_r=6; second pixel out 0, e=6. Write to addr 0 = (15*3)>>>4 + (6... expected value from golden model) — bench compares all writes against a bit-exact C model across a 16-pixel line.
3. Second line, eb_rd_data forced -256, err_r=-200, pixel 0 -> s=-456, clamps to -256, q=0, e=-256; with ERR_SAT_STATS_EN, sat_count increments by 1.
4. out_ready held low 10 cycles in EMIT -> out_valid and out_pixel stable; no eb_wr_en; in_ready=0.
5. End of line H_ACTIVE=8 -> FLUSH writes addr 7; err_r is 0 for pixel 0 of the next line; first_line clears.
6. frame_start asserted in SUM -> next cycle IDLE, x=0, no write or out_valid. The following line reads as if first_line (ea=0).

Source files
------------

// File: rtl/err_diffuse_pkg.sv
// Shared types and constants for the Floyd-Steinberg error-diffusion sequencer.
// Holds the FSM state enum, datapath widths, diffusion weights and the
// arithmetic helper that scales a residual error by k/16.
package err_diffuse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SUM,
        EMIT,
        FLUSH
    } state_e;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned ERR_W = 9;
    localparam int unsigned SUM_W = 11;

    // Neighbour weights in sixteenths: right, below-left, below, below-right
    localparam int unsigned WGT_RIGHT  = 7;
    localparam int unsigned WGT_DL     = 3;
    localparam int unsigned WGT_DOWN   = 5;
    localparam int unsigned WGT_DR     = 1;
    localparam int unsigned DIFF_SHIFT = 4;

    // (e * k) >>> 4 with floor rounding; |e| <= 256 and k <= 7 fit in 14 bits
    function automatic logic signed [ERR_W-1:0] diffuse_term(
        input logic signed [ERR_W-1:0] e,
        input logic [3:0]              k
    );
        logic signed [ERR_W+4:0] prod;
        prod = $signed({{5{e[ERR_W-1]}}, e}) * $signed({{(ERR_W+1){1'b0}}, k});
        return ERR_W'(prod >>> DIFF_SHIFT);
    endfunction

endpackage

// File: rtl/err_diffuse_calc.sv
// Per-pixel arithmetic of the SUM stage: add grey value and both carried
// errors, clip to 9-bit signed, quantize to OUT_BITS and form the residual.
// Ports:
//   pixel_i   unsigned grey value
//   ea_i      error from the line above (already zeroed on a first line)
//   err_i     error carried from the left neighbour
//   q_o_c     quantized output value
//   e_o_c     residual error c - (q << (8-OUT_BITS))
//   clip_o_c  the 11-bit sum fell outside [-256, 255]
module err_diffuse_calc
    import err_diffuse_pkg::*;
#(
    parameter int unsigned OUT_BITS = 4
) (
    input  logic [PIX_W-1:0]        pixel_i,
    input  logic signed [ERR_W-1:0] ea_i,
    input  logic signed [ERR_W-1:0] err_i,
    output logic [OUT_BITS-1:0]     q_o_c,
    output logic signed [ERR_W-1:0] e_o_c,
    output logic                    clip_o_c
);

    localparam int unsigned DROP = PIX_W - OUT_BITS;
    localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(-256);
    localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(255);
    localparam logic signed [ERR_W-1:0] ERR_LO = ERR_W'(-256);
    localparam logic signed [ERR_W-1:0] ERR_HI = ERR_W'(255);

    logic signed [SUM_W-1:0] sum;
    logic signed [ERR_W-1:0] clipped;
    logic [ERR_W-1:0]        recon;

    // Sum, saturate, quantize, residual
    always_comb begin
        sum = $signed(SUM_W'(pixel_i)) + $signed(SUM_W'(ea_i)) + $signed(SUM_W'(err_i));
        clip_o_c = 1'b1;
        if (sum < SUM_LO) begin
            clipped = ERR_LO;
        end else if (sum > SUM_HI) begin
            clipped = ERR_HI;
        end else begin
            clipped  = sum[ERR_W-1:0];
            clip_o_c = 1'b0;
        end
        // negative intensities quantize to black
        q_o_c = clipped[ERR_W-1] ? '0 : clipped[PIX_W-1 -: OUT_BITS];
        recon = ERR_W'(q_o_c) << DROP;
        e_o_c = clipped - $signed(recon);
    end

endmodule

// File: rtl/err_diffuse_ctrl.sv
// Floyd-Steinberg error-diffusion sequencer for the e-paper pixel pipeline.
// Accepts one grey pixel at a time, reads the error stored for its column by
// the previous line, quantizes, and distributes the residual 7/3/5/1 to the
// right neighbour and the three neighbours on the next line. Next-line errors
// are accumulated in a three-column window and written to the external
// dual-port error buffer as each column becomes final.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              restart at pixel 0 of a first line
//   in_valid/in_ready/in_pixel     pixel input handshake
//   out_valid/out_ready/out_pixel  quantized pixel output handshake
//   eb_rd_en/eb_rd_addr/eb_rd_data error buffer read port (1-cycle latency)
//   eb_wr_en/eb_wr_addr/eb_wr_data error buffer write port
//   sat_count                clip counter, present when ERR_SAT_STATS_EN is defined
module err_diffuse_ctrl
    import err_diffuse_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1600,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_W-1:0]    in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_pixel,
    output logic                eb_rd_en,
    output logic [ADDR_W-1:0]   eb_rd_addr,
    input  logic [ERR_W-1:0]    eb_rd_data,
    output logic                eb_wr_en,
    output logic [ADDR_W-1:0]   eb_wr_addr,
    output logic [ERR_W-1:0]    eb_wr_data
`ifdef ERR_SAT_STATS_EN
    ,
    output logic [15:0]         sat_count
`endif
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       x_q, x_d;
    logic                    first_q, first_d;
    logic signed [ERR_W-1:0] err_r_q, err_r_d;
    logic signed [ERR_W-1:0] acc_m1_q, acc_m1_d;
    logic signed [ERR_W-1:0] acc_0_q, acc_0_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [OUT_BITS-1:0]     q_q, q_d;
    logic signed [ERR_W-1:0] e_q, e_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [ERR_W-1:0]        wr_data_q, wr_data_d;

    logic signed [ERR_W-1:0] ea_c, calc_e_c;
    logic [OUT_BITS-1:0]     calc_q_c;
    logic                    calc_clip_c;
    logic signed [ERR_W-1:0] t_right_c, t_dl_c, t_down_c, t_dr_c, acc_m1_upd_c;
    logic                    last_px_c;

`ifdef ERR_SAT_STATS_EN
    logic [15:0] sat_q, sat_d;
`else
    logic unused_clip;
    assign unused_clip = calc_clip_c;
`endif

    // Line above contributes nothing on the first line of a frame
    assign ea_c = first_q ? '0 : $signed(eb_rd_data);

    err_diffuse_calc #(
        .OUT_BITS (OUT_BITS)
    ) u_calc (
        .pixel_i  (pix_q),
        .ea_i     (ea_c),
        .err_i    (err_r_q),
        .q_o_c    (calc_q_c),
        .e_o_c    (calc_e_c),
        .clip_o_c (calc_clip_c)
    );

    // Diffusion terms of the registered residual
    assign t_right_c = diffuse_term(e_q, 4'(WGT_RIGHT));
    assign t_dl_c    = diffuse_term(e_q, 4'(WGT_DL));
    assign t_down_c  = diffuse_term(e_q, 4'(WGT_DOWN));
    assign t_dr_c    = diffuse_term(e_q, 4'(WGT_DR));
    assign last_px_c = (x_q == ADDR_W'(H_ACTIVE - 1));
    // Column x-1 is complete once pixel x adds its below-left share
    assign acc_m1_upd_c = (x_q == '0) ? acc_m1_q : acc_m1_q + t_dl_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        first_d   = first_q;
        err_r_d   = err_r_q;
        acc_m1_d  = acc_m1_q;
        acc_0_d   = acc_0_q;
        pix_d     = pix_q;
        q_d       = q_q;
        e_d       = e_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef ERR_SAT_STATS_EN
        sat_d     = sat_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d     = in_pixel;
                    rd_en_d   = 1'b1;
                    rd_addr_d = x_q;
                    state_d   = READ;
                end
            end
            READ: state_d = SUM;
            SUM: begin
                q_d     = calc_q_c;
                e_d     = calc_e_c;
                state_d = EMIT;
`ifdef ERR_SAT_STATS_EN
                if (calc_clip_c && (sat_q != 16'hFFFF)) begin
                    sat_d = sat_q + 16'd1;
                end
`endif
            end
            EMIT: begin
                if (out_ready) begin
                    err_r_d = last_px_c ? '0 : t_right_c;
                    if (x_q != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = x_q - ADDR_W'(1);
                        wr_data_d = acc_m1_upd_c;
                    end
                    // Slide window; the below-right share starts the new x+1 column
                    acc_m1_d = acc_0_q + t_down_c;
                    acc_0_d  = t_dr_c;
                    if (last_px_c) begin
                        state_d = FLUSH;
                    end else begin
                        x_d     = x_q + ADDR_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(H_ACTIVE - 1);
                wr_data_d = acc_m1_q;
                acc_m1_d  = '0;
                acc_0_d   = '0;
                err_r_d   = '0;
                x_d       = '0;
                first_d   = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort whatever is in flight and restart on a first line
        if (frame_start) begin
            state_d  = IDLE;
            x_d      = '0;
            err_r_d  = '0;
            acc_m1_d = '0;
            acc_0_d  = '0;
            first_d  = 1'b1;
            rd_en_d  = 1'b0;
            wr_en_d  = 1'b0;
`ifdef ERR_SAT_STATS_EN
            sat_d    = '0;
`endif
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            first_q     <= 1'b1;
            err_r_q     <= '0;
            acc_m1_q    <= '0;
            acc_0_q     <= '0;
            pix_q       <= '0;
            q_q         <= '0;
            e_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef ERR_SAT_STATS_EN
            sat_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            first_q     <= first_d;
            err_r_q     <= err_r_d;
            acc_m1_q    <= acc_m1_d;
            acc_0_q     <= acc_0_d;
            pix_q       <= pix_d;
            q_q         <= q_d;
            e_q         <= e_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef ERR_SAT_STATS_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_pixel  = q_q;
    assign eb_rd_en   = rd_en_q;
    assign eb_rd_addr = rd_addr_q;
    assign eb_wr_en   = wr_en_q;
    assign eb_wr_addr = wr_addr_q;
    assign eb_wr_data = wr_data_q;
`ifdef ERR_SAT_STATS_EN
    assign sat_count  = sat_q;
`endif

endmodule

// File: tb/tb_err_diffuse_ctrl.sv
// Scoreboard bench for err_diffuse_ctrl: a line-array Floyd-Steinberg model
// predicts every quantized pixel and every error-buffer write; monitors pop
// and compare as the DUT presents them. Includes a behavioural error RAM.
module tb_err_diffuse_ctrl;

    localparam int H    = 8;
    localparam int AW   = 4;
    localparam int OB   = 4;
    localparam int DROP = 8 - OB;

    logic clk = 1'b0;
    logic rst, frame_start, in_valid, in_ready, out_valid, out_ready;
    logic eb_rd_en, eb_wr_en;
    logic [7:0]    in_pixel;
    logic [OB-1:0] out_pixel;
    logic [AW-1:0] eb_rd_addr, eb_wr_addr;
    logic [8:0]    eb_rd_data, eb_wr_data;
`ifdef ERR_SAT_STATS_EN
    logic [15:0]   sat_count;
`endif

    always #5 clk = ~clk;

    err_diffuse_ctrl #(
        .H_ACTIVE (H),
        .ADDR_W   (AW),
        .OUT_BITS (OB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .eb_rd_en    (eb_rd_en),
        .eb_rd_addr  (eb_rd_addr),
        .eb_rd_data  (eb_rd_data),
        .eb_wr_en    (eb_wr_en),
        .eb_wr_addr  (eb_wr_addr),
        .eb_wr_data  (eb_wr_data)
`ifdef ERR_SAT_STATS_EN
        ,
        .sat_count   (sat_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    int exp_out[$];
    int exp_wa[$];
    int exp_wd[$];

    // External error RAM with one-cycle read latency and a bench back door
    logic [8:0]    mem [0:(1<<AW)-1];
    logic          inj_en = 1'b0;
    logic [AW-1:0] inj_addr = '0;
    logic [8:0]    inj_data = '0;
    always @(posedge clk) begin
        if (eb_wr_en) mem[eb_wr_addr] <= eb_wr_data;
        if (inj_en) mem[inj_addr] <= inj_data;
        if (eb_rd_en) eb_rd_data <= mem[eb_rd_addr];
    end

    // Reference model: whole-line error arrays
    int cur[H];
    int nxt[H];
    int m_err, m_x, m_sat;
    bit m_first;

    function automatic int t16(input int e, input int k);
        return (e * k) >>> 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < H; i++) begin
            cur[i] = 0;
            nxt[i] = 0;
        end
        m_err = 0; m_x = 0; m_sat = 0; m_first = 1'b1;
    endtask

    task automatic model_pixel(input int p);
        int ea, s, c, q, e;
        ea = m_first ? 0 : cur[m_x];
        s  = p + ea + m_err;
        if (s < -256) begin
            c = -256; m_sat++;
        end else if (s > 255) begin
            c = 255; m_sat++;
        end else begin
            c = s;
        end
        q = (c < 0) ? 0 : (c >> DROP);
        e = c - (q << DROP);
        exp_out.push_back(q);
        if (m_x > 0) nxt[m_x-1] += t16(e, 3);
        nxt[m_x] += t16(e, 5);
        if (m_x + 1 < H) nxt[m_x+1] += t16(e, 1);
        if (m_x > 0) begin
            exp_wa.push_back(m_x - 1);
            exp_wd.push_back(nxt[m_x-1]);
        end
        if (m_x == H - 1) begin
            exp_wa.push_back(H - 1);
            exp_wd.push_back(nxt[H-1]);
            for (int i = 0; i < H; i++) begin
                cur[i] = nxt[i];
                nxt[i] = 0;
            end
            m_err = 0; m_x = 0; m_first = 1'b0;
        end else begin
            m_err = t16(e, 7);
            m_x++;
        end
    endtask

    // Downstream ready: random, with requested long stalls
    int stall_req = 0;
    int stall_seen = 0;
    int hold = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_req != stall_seen) begin
                stall_seen = stall_req;
                hold = 14;
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Output monitor
    bit         prev_stall = 1'b0;
    logic [OB-1:0] prev_pix = '0;
    int         ev;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                tests++;
                if (in_ready) begin
                    fails++;
                    $display("FAIL in_ready_during_emit got %0b want 0", in_ready);
                end
                if (prev_stall) begin
                    tests++;
                    if (out_pixel !== prev_pix || eb_wr_en !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_hold got pix %0d wr %0b want pix %0d wr 0", out_pixel, eb_wr_en, prev_pix);
                    end
                end
                if (out_ready) begin
                    tests++;
                    if (exp_out.size() == 0) begin
                        fails++;
                        $display("FAIL out_unexpected got %0d want none", out_pixel);
                    end else begin
                        ev = exp_out.pop_front();
                        if (out_pixel !== OB'(ev)) begin
                            fails++;
                            $display("FAIL out_pixel got %0d want %0d", out_pixel, ev);
                        end
                    end
                end
                prev_stall = !out_ready;
                prev_pix   = out_pixel;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Error-buffer write monitor
    int wa, wd, got_d;
    always @(negedge clk) begin
        if (!rst && eb_wr_en) begin
            tests++;
            got_d = $signed(eb_wr_data);
            if (eb_rd_en) begin
                fails++;
                $display("FAIL rd_wr_same_cycle got rd %0b want 0", eb_rd_en);
            end else if (exp_wa.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected got addr %0d data %0d want none", eb_wr_addr, got_d);
            end else begin
                wa = exp_wa.pop_front();
                wd = exp_wd.pop_front();
                if (eb_wr_addr !== AW'(wa) || got_d != wd) begin
                    fails++;
                    $display("FAIL eb_write got addr %0d data %0d want addr %0d data %0d", eb_wr_addr, got_d, wa, wd);
                end
            end
        end
    end

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pixel(input int p, input bit do_model);
        bit ok;
        ok = 1'b0;
        in_pixel = 8'(p);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            if (do_model) model_pixel(p);
            #1 in_valid = 1'b0;
        end else begin
            tests++; fails++;
            $display("FAIL accept_timeout got in_ready 0 want 1");
            in_valid = 1'b0;
        end
    endtask

    task automatic send_line(input int px[H]);
        for (int i = 0; i < H; i++) begin
            send_pixel(px[i], 1'b1);
            idle_gap();
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (exp_out.size() == 0 && exp_wa.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain got %0d outs %0d writes pending want 0", exp_out.size(), exp_wa.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic inject(input int addr, input int val);
        inj_addr = AW'(addr);
        inj_data = 9'(val);
        inj_en   = 1'b1;
        @(posedge clk); #1;
        inj_en   = 1'b0;
        cur[addr] = val;
    endtask

`ifdef ERR_SAT_STATS_EN
    task automatic check_sat();
        tests++;
        if (sat_count !== 16'(m_sat)) begin
            fails++;
            $display("FAIL sat_count got %0d want %0d", sat_count, m_sat);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    int px[H];
    initial begin
        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_pixel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || eb_rd_en !== 1'b0 || eb_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got rdy %0b ov %0b rd %0b wr %0b want 1 0 0 0", in_ready, out_valid, eb_rd_en, eb_wr_en);
        end
`ifdef ERR_SAT_STATS_EN
        check_sat_reset: begin
            tests++;
            if (sat_count !== 16'd0) begin
                fails++;
                $display("FAIL sat_reset got %0d want 0", sat_count);
            end
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // First line: mid-grey pair, then a small residual carried right
        px = '{128, 128, 15, 0, 0, 0, 0, 0};
        for (int i = 4; i < H; i++) px[i] = $urandom_range(0, 255);
        send_line(px);
        drain();

        // Second line with a forced -256 above: negative clip on pixel 1
        inject(0, -256);
        inject(1, -256);
        px = '{0, 0, 255, 255, 0, 0, 0, 0};
        for (int i = 4; i < H; i++) px[i] = $urandom_range(0, 255);
        send_line(px);
        drain();
`ifdef ERR_SAT_STATS_EN
        check_sat();
`endif

        // Random line with a long output stall on pixel 2
        for (int i = 0; i < H; i++) begin
            if (i == 2) stall_req++;
            send_pixel($urandom_range(0, 255), 1'b1);
            idle_gap();
        end
        drain();

        // Abort pixel 3 while it is in SUM
        for (int i = 0; i < 3; i++) begin
            send_pixel($urandom_range(0, 255), 1'b1);
            idle_gap();
        end
        send_pixel(200, 1'b0);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || eb_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_state got ov %0b rdy %0b wr %0b want 0 1 0", out_valid, in_ready, eb_wr_en);
        end
        // frame_start in IDLE wins over a same-cycle pixel
        @(posedge clk); #1;
        frame_start = 1'b1; in_valid = 1'b1; in_pixel = 8'd77;
        @(posedge clk); #1;
        frame_start = 1'b0; in_valid = 1'b0;
        drain();
`ifdef ERR_SAT_STATS_EN
        check_sat();
`endif

        // New frame: all-white line (positive clips), then random lines
        for (int i = 0; i < H; i++) px[i] = 255;
        send_line(px);
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < H; i++) px[i] = $urandom_range(0, 255);
            send_line(px);
        end
        for (int i = 0; i < H; i++) px[i] = 0;
        send_line(px);
        drain();
`ifdef ERR_SAT_STATS_EN
        check_sat();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
